// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//
// Shares the register file's single write port among NUM_REQ writeback
// sources (0 = ALU, 1 = load unit, 2 = mul/div) with a round-robin arbiter.
// It also keeps a per-register scoreboard of pending writes, so decode can
// stall on read-after-write hazards.
//
// Ports
//   Clk, Reset            clock; asynchronous active-high reset
//   ReqValid/ReqReg/ReqData  per-requester write request (packed, requester i
//                            in slice i)
//   ReqReady              one-hot combinational grant
//   RegWrite/WriteRegister/WriteData  registered write port to Registers
//   ReserveValid/ReserveReg           decode marks a destination as pending
//   ReadRegister1/ReadRegister2       decode source registers
//   Busy1/Busy2           combinational pending-write flags for the sources
//   ReserveConflict       registered pulse: reserve hit an already-busy reg
module regfile_write_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             ReqValid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  ReqReg,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  ReqData,
    output logic [NUM_REQ-1:0]             ReqReady,
    output logic                           RegWrite,
    output logic [ADDR_WIDTH-1:0]          WriteRegister,
    output logic [DATA_WIDTH-1:0]          WriteData,
    input  logic                           ReserveValid,
    input  logic [ADDR_WIDTH-1:0]          ReserveReg,
    input  logic [ADDR_WIDTH-1:0]          ReadRegister1,
    input  logic [ADDR_WIDTH-1:0]          ReadRegister2,
    output logic                           Busy1,
    output logic                           Busy2,
    output logic                           ReserveConflict
);

    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    // Round-robin pointer: index of the most recently granted requester.
    logic [IDX_W-1:0]      last_q;

    // Arbitration results for the current cycle.
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      cand;
    logic                  xfer;

    // Request fields of the granted requester.
    logic [ADDR_WIDTH-1:0] sel_reg;
    logic [DATA_WIDTH-1:0] sel_data;

    // Scoreboard of pending writes, one bit per architectural register.
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic                  clear_hit;
    logic                  set_hit;
    logic                  conflict_d;

    // Search starts just after the last winner and wraps around, so each
    // requester waits at most NUM_REQ-1 transfers. Only ReqValid and the
    // pointer feed this search, which keeps ReqReady free of data paths.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        xfer      = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!xfer && ReqValid[cand]) begin
                xfer        = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign ReqReady = grant;

    // Grant is one-hot, so OR-ing the masked slices acts as a mux.
    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_reg  = sel_reg  | ReqReg[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = sel_data | ReqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A transfer to $zero is still consumed (pointer moves) but never
    // produces a write or touches the scoreboard.
    assign clear_hit = xfer && (sel_reg != '0);
    assign set_hit   = ReserveValid && (ReserveReg != '0);

    // Set is applied after clear so a same-cycle reserve of the register
    // being written leaves it pending for the newly issued instruction.
    always_comb begin
        busy_d = busy_q;
        if (clear_hit) begin
            busy_d[sel_reg] = 1'b0;
        end
        if (set_hit) begin
            busy_d[ReserveReg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // A reserve only conflicts if the register stays busy through this edge,
    // i.e. it is not being retired by the write granted in the same cycle.
    assign conflict_d = set_hit && busy_q[ReserveReg] &&
                        !(clear_hit && (sel_reg == ReserveReg));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_q <= LAST_INIT;
        end else if (xfer) begin
            last_q <= grant_idx;
        end
    end

    // Write port register. Address/data only load on a real write so they
    // hold their previous values on idle cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= clear_hit;
            if (clear_hit) begin
                WriteRegister <= sel_reg;
                WriteData     <= sel_data;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q          <= '0;
            ReserveConflict <= 1'b0;
        end else begin
            busy_q          <= busy_d;
            ReserveConflict <= conflict_d;
        end
    end

    // Busy reflects the registered scoreboard only; there is no bypass of
    // a write or reserve happening in the current cycle.
    assign Busy1 = (ReadRegister1 != '0) && busy_q[ReadRegister1];
    assign Busy2 = (ReadRegister2 != '0) && busy_q[ReadRegister2];

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler
//
// Directed, table-driven bench for regfile_write_scheduler. Each table
// record gives one cycle of inputs, the combinational outputs expected
// before the clock edge and the registered outputs expected after it.
// Reset behaviour mid-operation is covered by a hand-written sequence.
module tb_regfile_write_scheduler;

    localparam int NUM_REQ    = 3;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    logic                          Clk;
    logic                          Reset;
    logic [NUM_REQ-1:0]            ReqValid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] ReqReg;
    logic [NUM_REQ*DATA_WIDTH-1:0] ReqData;
    logic [NUM_REQ-1:0]            ReqReady;
    logic                          RegWrite;
    logic [ADDR_WIDTH-1:0]         WriteRegister;
    logic [DATA_WIDTH-1:0]         WriteData;
    logic                          ReserveValid;
    logic [ADDR_WIDTH-1:0]         ReserveReg;
    logic [ADDR_WIDTH-1:0]         ReadRegister1;
    logic [ADDR_WIDTH-1:0]         ReadRegister2;
    logic                          Busy1;
    logic                          Busy2;
    logic                          ReserveConflict;

    typedef struct {
        bit          doReset;
        logic [2:0]  valid;
        logic [4:0]  reg0, reg1, reg2;
        logic [31:0] data0, data1, data2;
        bit          resv;
        logic [4:0]  resReg;
        logic [4:0]  rr1, rr2;
        logic [2:0]  expReady;
        bit          expBusy1, expBusy2;
        bit          expRegWrite;
        logic [4:0]  expWriteReg;
        logic [31:0] expWriteData;
        bit          expConflict;
    } vec_t;

    vec_t vecs[$];
    int   checkCount = 0;
    int   errorCount = 0;

    regfile_write_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ReqValid       (ReqValid),
        .ReqReg         (ReqReg),
        .ReqData        (ReqData),
        .ReqReady       (ReqReady),
        .RegWrite       (RegWrite),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .ReserveValid   (ReserveValid),
        .ReserveReg     (ReserveReg),
        .ReadRegister1  (ReadRegister1),
        .ReadRegister2  (ReadRegister2),
        .Busy1          (Busy1),
        .Busy2          (Busy2),
        .ReserveConflict(ReserveConflict)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input bit rst, input logic [2:0] v,
                          input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                          input bit rv, input logic [4:0] rreg,
                          input logic [4:0] a1, input logic [4:0] a2,
                          input logic [2:0] er, input bit eb1, input bit eb2,
                          input bit erw, input logic [4:0] ewr, input logic [31:0] ewd,
                          input bit ec);
        vec_t t;
        t.doReset = rst;  t.valid = v;
        t.reg0 = r0;  t.reg1 = r1;  t.reg2 = r2;
        t.data0 = d0; t.data1 = d1; t.data2 = d2;
        t.resv = rv;  t.resReg = rreg;
        t.rr1 = a1;   t.rr2 = a2;
        t.expReady = er; t.expBusy1 = eb1; t.expBusy2 = eb2;
        t.expRegWrite = erw; t.expWriteReg = ewr; t.expWriteData = ewd;
        t.expConflict = ec;
        vecs.push_back(t);
    endtask

    task automatic driveIdle();
        ReqValid     = '0;
        ReqReg       = '0;
        ReqData      = '0;
        ReserveValid = 1'b0;
        ReserveReg   = '0;
    endtask

    // Called 1 ns after a rising edge: optional reset pulse, drive inputs,
    // check combinational outputs mid-cycle, then registered ones after the edge.
    task automatic applyStimulus(input int n, input vec_t t);
        if (t.doReset) begin
            Reset = 1'b1;
            #1;
            Reset = 1'b0;
            #1;
        end
        ReqValid      = t.valid;
        ReqReg        = {t.reg2, t.reg1, t.reg0};
        ReqData       = {t.data2, t.data1, t.data0};
        ReserveValid  = t.resv;
        ReserveReg    = t.resReg;
        ReadRegister1 = t.rr1;
        ReadRegister2 = t.rr2;
        #3;
        checkOutput($sformatf("ready[v%0d]", n), 32'(ReqReady), 32'(t.expReady));
        checkOutput($sformatf("busy1[v%0d]", n), 32'(Busy1), 32'(t.expBusy1));
        checkOutput($sformatf("busy2[v%0d]", n), 32'(Busy2), 32'(t.expBusy2));
        @(posedge Clk);
        #1;
        checkOutput($sformatf("regwrite[v%0d]", n), 32'(RegWrite), 32'(t.expRegWrite));
        checkOutput($sformatf("writereg[v%0d]", n), 32'(WriteRegister), 32'(t.expWriteReg));
        checkOutput($sformatf("writedata[v%0d]", n), WriteData, t.expWriteData);
        checkOutput($sformatf("conflict[v%0d]", n), 32'(ReserveConflict), 32'(t.expConflict));
    endtask

    initial begin
        Reset         = 1'b1;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        driveIdle();

        //      rst valid r0 r1 r2  d0     d1            d2     rv rreg a1 a2  ready b1 b2 rw wr wd            cf
        // Single ALU write, then idle: address/data hold.
        addVec(1, 3'b001, 1, 0, 0, 32'd5,  32'd0,        32'd0, 0, 0,   0, 0,  3'b001, 0, 0, 1, 1, 32'd5,        0);
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 0, 0,   0, 0,  3'b000, 0, 0, 0, 1, 32'd5,        0);
        // All three requesting from a fresh reset: round-robin 0,1,2,0,1,2.
        addVec(1, 3'b111, 2, 3, 4, 32'h20, 32'h30,       32'h40, 0, 0,  0, 0,  3'b001, 0, 0, 1, 2, 32'h20,       0);
        addVec(0, 3'b111, 2, 3, 4, 32'h20, 32'h30,       32'h40, 0, 0,  0, 0,  3'b010, 0, 0, 1, 3, 32'h30,       0);
        addVec(0, 3'b111, 2, 3, 4, 32'h20, 32'h30,       32'h40, 0, 0,  0, 0,  3'b100, 0, 0, 1, 4, 32'h40,       0);
        addVec(0, 3'b111, 2, 3, 4, 32'h20, 32'h30,       32'h40, 0, 0,  0, 0,  3'b001, 0, 0, 1, 2, 32'h20,       0);
        addVec(0, 3'b111, 2, 3, 4, 32'h20, 32'h30,       32'h40, 0, 0,  0, 0,  3'b010, 0, 0, 1, 3, 32'h30,       0);
        addVec(0, 3'b111, 2, 3, 4, 32'h20, 32'h30,       32'h40, 0, 0,  0, 0,  3'b100, 0, 0, 1, 4, 32'h40,       0);
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 0, 0,   0, 0,  3'b000, 0, 0, 0, 4, 32'h40,       0);
        // Reserve r7, load writes r7: Busy1 visible until the transfer edge.
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 1, 7,   7, 0,  3'b000, 0, 0, 0, 4, 32'h40,       0);
        addVec(0, 3'b010, 0, 7, 0, 32'd0,  32'hDEADBEEF, 32'd0, 0, 0,   7, 0,  3'b010, 1, 0, 1, 7, 32'hDEADBEEF, 0);
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 0, 0,   7, 0,  3'b000, 0, 0, 0, 7, 32'hDEADBEEF, 0);
        // Write to $zero: granted, no RegWrite, pointer still moves to 0.
        addVec(0, 3'b001, 0, 0, 0, 32'd9,  32'd0,        32'd0, 0, 0,   0, 0,  3'b001, 0, 0, 0, 7, 32'hDEADBEEF, 0);
        addVec(0, 3'b011, 5, 6, 0, 32'h55, 32'h66,       32'd0, 0, 0,   0, 0,  3'b010, 0, 0, 1, 6, 32'h66,       0);
        addVec(0, 3'b001, 5, 0, 0, 32'h55, 32'd0,        32'd0, 0, 0,   0, 0,  3'b001, 0, 0, 1, 5, 32'h55,       0);
        // Reserve r3; then reserve + write r3 together (set wins, no conflict);
        // then reserve r3 again for a one-cycle conflict pulse.
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 1, 3,   0, 3,  3'b000, 0, 0, 0, 5, 32'h55,       0);
        addVec(0, 3'b100, 0, 0, 3, 32'd0,  32'd0,        32'h33, 1, 3,  0, 3,  3'b100, 0, 1, 1, 3, 32'h33,       0);
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 0, 0,   0, 3,  3'b000, 0, 1, 0, 3, 32'h33,       0);
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 1, 3,   0, 3,  3'b000, 0, 1, 0, 3, 32'h33,       1);
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 0, 0,   0, 3,  3'b000, 0, 1, 0, 3, 32'h33,       0);
        // Reserving $zero is ignored.
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 1, 0,   0, 3,  3'b000, 0, 1, 0, 3, 32'h33,       0);
        addVec(0, 3'b000, 0, 0, 0, 32'd0,  32'd0,        32'd0, 0, 0,   0, 3,  3'b000, 0, 1, 0, 3, 32'h33,       0);

        // Reset state
        #12;
        checkOutput("reset_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("reset_writereg", 32'(WriteRegister), 32'd0);
        checkOutput("reset_writedata", WriteData, 32'd0);
        checkOutput("reset_conflict", 32'(ReserveConflict), 32'd0);
        checkOutput("reset_ready", 32'(ReqReady), 32'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(i, vecs[i]);
        end

        // Reserve r9, transfer r10, then reset in the cycle after the transfer.
        driveIdle();
        ReserveValid  = 1'b1;
        ReserveReg    = 5'd9;
        ReadRegister1 = 5'd9;
        ReadRegister2 = 5'd3;
        @(posedge Clk);
        #1;
        ReserveValid = 1'b0;
        ReqValid     = 3'b010;
        ReqReg       = {5'd0, 5'd10, 5'd0};
        ReqData      = {32'd0, 32'hAA, 32'd0};
        #3;
        checkOutput("seq_busy1_before", 32'(Busy1), 32'd1);
        @(posedge Clk);
        #1;
        checkOutput("seq_regwrite_xfer", 32'(RegWrite), 32'd1);
        driveIdle();
        Reset = 1'b1;
        #1;
        checkOutput("seq_rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("seq_rst_writereg", 32'(WriteRegister), 32'd0);
        checkOutput("seq_rst_writedata", WriteData, 32'd0);
        checkOutput("seq_rst_busy1", 32'(Busy1), 32'd0);
        checkOutput("seq_rst_busy2", 32'(Busy2), 32'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("seq_post_rst_regwrite", 32'(RegWrite), 32'd0);
        ReqValid = 3'b011;
        ReqReg   = {5'd0, 5'd12, 5'd11};
        ReqData  = {32'd0, 32'hC2, 32'hB1};
        #3;
        checkOutput("seq_restart_ready", 32'(ReqReady), 32'b001);
        @(posedge Clk);
        #1;
        checkOutput("seq_restart_writereg", 32'(WriteRegister), 32'd11);
        checkOutput("seq_restart_writedata", WriteData, 32'hB1);
        driveIdle();
        @(posedge Clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
